// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// Latency: push into empty FIFO at edge N -> pop at N+1 -> start bit on txd_o from N+2.
// Backpressure: ready_o drops while the byte FIFO is full; frames run back-to-back.

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_vld,
   input  logic [WIDTH-1:0]         push_dat,
   output logic                     push_rdy,
   output logic                     pop_vld,
   output logic [WIDTH-1:0]         pop_dat,
   input  logic                     pop_rdy,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign push_rdy = (count != CW'(DEPTH));
   assign pop_vld  = (count != '0);
   assign pop_dat  = mem[rd_ptr];
   assign push     = push_vld && push_rdy;
   assign pop      = pop_rdy && pop_vld;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= push_dat;
   end
endmodule

module uart_tx_fifo #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [7:0]                    data_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   output logic                          txd_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
   localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             line_d;
   logic             bit_end;
   logic             fifo_pop_vld;
   logic             fifo_pop_rdy;
   logic [7:0]       fifo_pop_dat;
`ifdef UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_vld (valid_i),
      .push_dat (data_i),
      .push_rdy (ready_o),
      .pop_vld  (fifo_pop_vld),
      .pop_dat  (fifo_pop_dat),
      .pop_rdy  (fifo_pop_rdy),
      .count    (fifo_count_o)
   );

   assign bit_end = (cnt_q == '0);

   // txd_o and busy_o are registered views of the current state, so both
   // trail the FSM by one cycle and stay aligned with each other.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         txd_o   <= 1'b1;
         busy_o  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         txd_o   <= line_d;
         busy_o  <= (state_q != IDLE);
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = bit_end ? cnt_q : cnt_q - CNT_W'(1);
      idx_d        = idx_q;
      shreg_d      = shreg_q;
      line_d       = 1'b1;
      fifo_pop_rdy = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d        = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (fifo_pop_vld) begin
               fifo_pop_rdy = 1'b1;
               shreg_d      = fifo_pop_dat;
               cnt_d        = CNT_RELOAD;
               state_d      = START;
`ifdef UART_TX_PARITY_EN
               par_d        = ^fifo_pop_dat;
`endif
            end
         end
         START: begin
            line_d = 1'b0;
            if (bit_end) begin
               cnt_d   = CNT_RELOAD;
               idx_d   = 3'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            line_d = shreg_q[0];
            if (bit_end) begin
               cnt_d   = CNT_RELOAD;
               shreg_d = {1'b0, shreg_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            line_d = par_q;
            if (bit_end) begin
               cnt_d   = CNT_RELOAD;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            line_d = 1'b1;
            if (bit_end) begin
               // Chain straight into the next start bit when a byte is waiting.
               if (fifo_pop_vld) begin
                  fifo_pop_rdy = 1'b1;
                  shreg_d      = fifo_pop_dat;
                  cnt_d        = CNT_RELOAD;
                  state_d      = START;
`ifdef UART_TX_PARITY_EN
                  par_d        = ^fifo_pop_dat;
`endif
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: scoreboard of pushed bytes checked by a line decoder.
module tb_uart_tx_fifo;
   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 100_000;
   localparam int DEPTH  = 4;
   localparam int CPB    = 10;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic       ready;
   logic       txd;
   logic       busy;
   logic [2:0] fifo_count;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb[$];
   int         starts[$];
   int         frames_rx = 0;
   int         cyc = 0;

   logic       mon_act = 1'b0;
   int         mon_cyc = 0;
   int         mon_bit = 0;
   logic [7:0] mon_byte = 8'h00;
   logic [7:0] mon_exp;

   uart_tx_fifo #(
      .CLK_FREQ_HZ (CLK_HZ),
      .BAUD_RATE   (BAUD),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .data_i       (data),
      .valid_i      (valid),
      .ready_o      (ready),
      .txd_o        (txd),
      .busy_o       (busy),
      .fifo_count_o (fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Line decoder: samples mid-bit and retires one scoreboard entry per frame.
   always @(negedge clk) begin
      if (rst) begin
         mon_act = 1'b0;
      end else if (!mon_act) begin
         if (txd === 1'b0) begin
            mon_act = 1'b1;
            mon_cyc = 0;
            starts.push_back(cyc);
         end
      end else begin
         mon_cyc++;
      end
      if (mon_act && !rst && (mon_cyc % CPB) == CPB / 2) begin
         mon_bit = mon_cyc / CPB;
         if (mon_bit == 0) begin
            check("start_bit", 32'(txd), 32'd0);
         end else if (mon_bit <= 8) begin
            mon_byte[mon_bit-1] = txd;
`ifdef UART_TX_PARITY_EN
         end else if (mon_bit == 9) begin
            check("parity_bit", 32'(txd), 32'(^mon_byte));
`endif
         end else begin
            check("stop_bit", 32'(txd), 32'd1);
            check("frame_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               mon_exp = sb.pop_front();
               check("frame_byte", 32'(mon_byte), 32'(mon_exp));
            end
            frames_rx++;
         end
      end
      if (mon_act && mon_cyc == FRAME_CYC - 1) mon_act = 1'b0;
   end

   task automatic push(input logic [7:0] b, output int waited);
      waited = 0;
      @(negedge clk);
      data  = b;
      valid = 1'b1;
      while (ready !== 1'b1 && waited < 5000) begin
         @(negedge clk);
         waited++;
      end
      check("push_accept", 32'(ready === 1'b1), 32'd1);
      sb.push_back(b);
      @(posedge clk);
      #1;
      valid = 1'b0;
      data  = ~b;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(busy === 1'b0 && fifo_count === 3'd0) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_timeout", 32'(n < 5000), 32'd1);
   endtask

   task automatic measure_busy(output int n);
      int w = 0;
      n = 0;
      while (busy !== 1'b1 && w < 300) begin
         @(posedge clk);
         #1;
         w++;
      end
      while (busy === 1'b1 && n < 2000) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int w;
      int n;
      int f0;
      int lows;

      // Reset and quiescent idle
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_count", 32'(fifo_count), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         check("idle_txd", 32'(txd), 32'd1);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_ready", 32'(ready), 32'd1);
         check("idle_count", 32'(fifo_count), 32'd0);
      end

      // Single frame 0xA5: latency and busy width
      push(8'hA5, w);
      check("t2_count_n", 32'(fifo_count), 32'd1);
      check("t2_txd_n", 32'(txd), 32'd1);
      @(posedge clk);
      #1;
      check("t2_count_n1", 32'(fifo_count), 32'd0);
      check("t2_txd_n1", 32'(txd), 32'd1);
      check("t2_busy_n1", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("t2_txd_n2", 32'(txd), 32'd0);
      check("t2_busy_n2", 32'(busy), 32'd1);
      measure_busy(n);
      check("t2_busy_cycles", 32'(n), 32'(FRAME_CYC));
      wait_idle();

      // Fill to full, hold the sixth byte, frames contiguous
      starts.delete();
      push(8'h00, w);
      push(8'hFF, w);
      push(8'h55, w);
      push(8'h81, w);
      push(8'h3C, w);
      check("t3_count_full", 32'(fifo_count), 32'd4);
      check("t3_ready_full", 32'(ready), 32'd0);
      push(8'hA7, w);
      check("t3_sixth_held", 32'(w > 50), 32'd1);
      wait_idle();
      check("t3_frames", 32'(starts.size()), 32'd6);
      for (int i = 1; i < starts.size(); i++)
         check("t3_frame_spacing", 32'(starts[i] - starts[i-1]), 32'(FRAME_CYC));

      // Push and pop on the same edge with two bytes queued
      push(8'h11, w);
      push(8'h22, w);
      push(8'h33, w);
      repeat (FRAME_CYC - 2) @(posedge clk);
      #1;
      check("t4_count_before", 32'(fifo_count), 32'd2);
      push(8'h44, w);
      check("t4_count_same_edge", 32'(fifo_count), 32'd2);
      wait_idle();

      // Reset at cycle 35 of a frame flushes everything
      push(8'hAA, w);
      push(8'hBB, w);
      push(8'hCC, w);
      repeat (34) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5_txd", 32'(txd), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_count", 32'(fifo_count), 32'd0);
      check("t5_ready", 32'(ready), 32'd1);
      rst = 1'b0;
      sb.delete();
      f0 = frames_rx;
      lows = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      check("t5_line_quiet", 32'(lows), 32'd0);
      check("t5_no_frames", 32'(frames_rx), 32'(f0));

      // Frame length and parity bytes
      push(8'h07, w);
      measure_busy(n);
      check("t6_len_07", 32'(n), 32'(FRAME_CYC));
      wait_idle();
      push(8'h03, w);
      measure_busy(n);
      check("t6_len_03", 32'(n), 32'(FRAME_CYC));
      wait_idle();

      repeat (20) @(posedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("frames_total", 32'(frames_rx), 32'd13);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
